// File: rtl/home_event_scheduler_if.sv
// Request/grant bundle for the home event scheduler.
// Requests are level-sensitive with no handshake; grants are registered levels that stay valid while held.
interface home_event_scheduler_if;
    logic       SFD;
    logic       SRD;
    logic       SFA;
    logic       SW;
    logic       ST;
    logic [5:0] temperature;
    logic [2:0] A;
    logic [5:0] grant;
    logic       grant_valid;
    logic [7:0] switch_count;
    logic [1:0] dbg_state;

    modport master (
        output SFD, SRD, SFA, SW, ST, temperature,
        input  A, grant, grant_valid, switch_count, dbg_state
    );

    modport slave (
        input  SFD, SRD, SFA, SW, ST, temperature,
        output A, grant, grant_valid, switch_count, dbg_state
    );
endinterface

// File: rtl/home_event_scheduler.sv
// Round-robin actuator scheduler with min/max hold and a one-cycle break-before-make gap.
// Optional macro ALARM_PREEMPT_EN lets a fire-alarm request cut any other grant short.
module home_event_scheduler #(
    parameter int unsigned MIN_HOLD = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic                   clk,
    input logic                   reset,
    home_event_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] MIN_H = 8'(MIN_HOLD);
    localparam logic [7:0] MAX_H = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [5:0] req_q, req_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] switch_count_q, switch_count_d;
    logic [2:0] a_q, a_d;
    logic [5:0] grant_q, grant_d;
    logic       grant_valid_q, grant_valid_d;
`ifdef ALARM_PREEMPT_EN
    logic       preempt_q, preempt_d;
`endif

    logic [2:0] rr_sel;
    logic       rr_found;
    logic [3:0] pos;
    logic [5:0] others;
    logic       normal_exit;
    logic       enter_hold;
    logic [2:0] sel;

    // First pending request at or after rr_ptr, wrapping 5 -> 0.
    always_comb begin
        rr_sel   = 3'd0;
        rr_found = 1'b0;
        pos      = 4'd0;
        for (int k = 0; k < 6; k++) begin
            pos = 4'(rr_ptr_q) + 4'(k);
            if (pos >= 4'd6) pos = pos - 4'd6;
            if (!rr_found && req_q[pos[2:0]]) begin
                rr_found = 1'b1;
                rr_sel   = pos[2:0];
            end
        end
    end

    always_comb begin
        req_d = {bus.ST & (bus.temperature > 6'd30),
                 bus.ST & (bus.temperature < 6'd16),
                 bus.SW, bus.SFA, bus.SRD, bus.SFD};
        state_d        = state_q;
        idx_d          = idx_q;
        rr_ptr_d       = rr_ptr_q;
        hold_cnt_d     = hold_cnt_q;
        switch_count_d = switch_count_q;
        enter_hold     = 1'b0;
        sel            = rr_sel;
        others         = req_q & ~(6'b000001 << idx_q);
        normal_exit    = ((hold_cnt_q >= MIN_H) && !req_q[idx_q]) ||
                         ((hold_cnt_q == MAX_H) && (others != 6'd0));
`ifdef ALARM_PREEMPT_EN
        preempt_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rr_found) enter_hold = 1'b1;
            end
            HOLD: begin
                if (hold_cnt_q != MAX_H) hold_cnt_d = hold_cnt_q + 8'd1;
                if (normal_exit) begin
                    state_d  = GAP;
                    rr_ptr_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                end
`ifdef ALARM_PREEMPT_EN
                // Preemption leaves the round-robin pointer untouched.
                if (req_q[2] && idx_q != 3'd2) begin
                    state_d   = GAP;
                    preempt_d = 1'b1;
                    rr_ptr_d  = rr_ptr_q;
                end
`endif
            end
            GAP: begin
`ifdef ALARM_PREEMPT_EN
                if (preempt_q && req_q[2]) sel = 3'd2;
`endif
                if (rr_found) enter_hold = 1'b1;
                else          state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (enter_hold) begin
            state_d        = HOLD;
            idx_d          = sel;
            hold_cnt_d     = 8'd1;
            switch_count_d = switch_count_q + 8'd1;
        end

        a_d           = (state_d == HOLD) ? idx_d + 3'd1 : 3'd0;
        grant_d       = (state_d == HOLD) ? (6'b000001 << idx_d) : 6'd0;
        grant_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            req_q          <= 6'd0;
            idx_q          <= 3'd0;
            rr_ptr_q       <= 3'd0;
            hold_cnt_q     <= 8'd0;
            switch_count_q <= 8'd0;
            a_q            <= 3'd0;
            grant_q        <= 6'd0;
            grant_valid_q  <= 1'b0;
`ifdef ALARM_PREEMPT_EN
            preempt_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            idx_q          <= idx_d;
            rr_ptr_q       <= rr_ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            switch_count_q <= switch_count_d;
            a_q            <= a_d;
            grant_q        <= grant_d;
            grant_valid_q  <= grant_valid_d;
`ifdef ALARM_PREEMPT_EN
            preempt_q      <= preempt_d;
`endif
        end
    end

    assign bus.A            = a_q;
    assign bus.grant        = grant_q;
    assign bus.grant_valid  = grant_valid_q;
    assign bus.switch_count = switch_count_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_home_event_scheduler.sv
// Self-checking bench for home_event_scheduler (MIN_HOLD=4, MAX_HOLD=16).
// Expected {A, switch_count} words are queued per cycle and popped one per clock.
module tb_home_event_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    home_event_scheduler_if bus ();

    home_event_scheduler #(.MIN_HOLD(4), .MAX_HOLD(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [10:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [5:0] onehot(input logic [2:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = (a == 3'(i + 1));
        return r;
    endfunction

    function automatic logic [10:0] ew(input logic [2:0] a, input logic [7:0] sc);
        return {a, sc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sfd, input logic srd, input logic sfa,
                         input logic sw, input logic st, input logic [5:0] temp);
        bus.SFD = sfd; bus.SRD = srd; bus.SFA = sfa;
        bus.SW  = sw;  bus.ST  = st;  bus.temperature = temp;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'($urandom_range(0, 63)));
        reset = 1'b1;
        for (int j = 0; j < 6; j++) exp_q.push_back(ew(3'd0, 8'd0));
        for (int j = 0; j < 6; j++) begin
            if (j == 3) begin
                reset = 1'b0;
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20);
            end
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (bus.A !== e[10:8] || bus.grant !== onehot(e[10:8]) ||
                bus.grant_valid !== (e[10:8] != 3'd0) || bus.switch_count !== e[7:0] ||
                bus.dbg_state !== 2'd0) begin
                miscompares++;
                $display("FAIL reset cyc%0d: got A=%0d grant=%b gv=%b cnt=%0d st=%0d, want A=%0d grant=%b gv=%b cnt=%0d st=0",
                         j, bus.A, bus.grant, bus.grant_valid, bus.switch_count, bus.dbg_state,
                         e[10:8], onehot(e[10:8]), e[10:8] != 3'd0, e[7:0]);
            end
        end
    endtask

    // SFD held from release: grant on 2nd edge, holds past MAX alone; a short SRD pulse is lost.
    task automatic test_first_grant();
        logic [10:0] e;
        apply_reset();
        for (int j = 0; j < 34; j++) begin
            if (j == 0)       exp_q.push_back(ew(3'd0, 8'd0));
            else if (j <= 30) exp_q.push_back(ew(3'd1, 8'd1));
            else              exp_q.push_back(ew(3'd0, 8'd1));
        end
        for (int j = 0; j < 34; j++) begin
            drive(j < 30, j == 5, 1'b0, 1'b0, 1'b0, 6'd20);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (bus.A !== e[10:8] || bus.grant !== onehot(e[10:8]) ||
                bus.grant_valid !== (e[10:8] != 3'd0) || bus.switch_count !== e[7:0]) begin
                miscompares++;
                $display("FAIL first_grant cyc%0d: got A=%0d grant=%b gv=%b cnt=%0d, want A=%0d grant=%b gv=%b cnt=%0d",
                         j, bus.A, bus.grant, bus.grant_valid, bus.switch_count,
                         e[10:8], onehot(e[10:8]), e[10:8] != 3'd0, e[7:0]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] e;
        apply_reset();
        for (int j = 0; j < 37; j++) begin
            if (j == 0)       exp_q.push_back(ew(3'd0, 8'd0));
            else if (j <= 16) exp_q.push_back(ew(3'd1, 8'd1));
            else if (j == 17) exp_q.push_back(ew(3'd0, 8'd1));
            else if (j <= 33) exp_q.push_back(ew(3'd4, 8'd2));
            else if (j == 34) exp_q.push_back(ew(3'd0, 8'd2));
            else              exp_q.push_back(ew(3'd1, 8'd3));
        end
        for (int j = 0; j < 37; j++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd20);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (bus.A !== e[10:8] || bus.grant !== onehot(e[10:8]) ||
                bus.grant_valid !== (e[10:8] != 3'd0) || bus.switch_count !== e[7:0]) begin
                miscompares++;
                $display("FAIL round_robin cyc%0d: got A=%0d grant=%b gv=%b cnt=%0d, want A=%0d grant=%b gv=%b cnt=%0d",
                         j, bus.A, bus.grant, bus.grant_valid, bus.switch_count,
                         e[10:8], onehot(e[10:8]), e[10:8] != 3'd0, e[7:0]);
            end
        end
    endtask

    task automatic test_min_hold();
        logic [10:0] e;
        apply_reset();
        for (int j = 0; j < 9; j++) begin
            if (j <= 1)      exp_q.push_back(ew(3'd0, 8'd0));
            else if (j <= 5) exp_q.push_back(ew(3'd2, 8'd1));
            else             exp_q.push_back(ew(3'd0, 8'd1));
        end
        for (int j = 0; j < 9; j++) begin
            drive(1'b0, j == 1, 1'b0, 1'b0, 1'b0, 6'd20);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (bus.A !== e[10:8] || bus.grant !== onehot(e[10:8]) ||
                bus.grant_valid !== (e[10:8] != 3'd0) || bus.switch_count !== e[7:0]) begin
                miscompares++;
                $display("FAIL min_hold cyc%0d: got A=%0d grant=%b gv=%b cnt=%0d, want A=%0d grant=%b gv=%b cnt=%0d",
                         j, bus.A, bus.grant, bus.grant_valid, bus.switch_count,
                         e[10:8], onehot(e[10:8]), e[10:8] != 3'd0, e[7:0]);
            end
        end
    endtask

    // Comfortable band (16..30) requests nothing; heater drops early but is held to MIN.
    task automatic test_temperature();
        logic [10:0] e;
        logic [5:0]  temp;
        apply_reset();
        for (int j = 0; j < 17; j++) begin
            if (j <= 6)       exp_q.push_back(ew(3'd0, 8'd0));
            else if (j <= 10) exp_q.push_back(ew(3'd5, 8'd1));
            else if (j == 11) exp_q.push_back(ew(3'd0, 8'd1));
            else              exp_q.push_back(ew(3'd6, 8'd2));
        end
        for (int j = 0; j < 17; j++) begin
            if (j == 0)      temp = 6'd16;
            else if (j == 1) temp = 6'd30;
            else if (j < 6)  temp = 6'($urandom_range(16, 30));
            else if (j < 8)  temp = 6'd10;
            else             temp = 6'd40;
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, temp);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (bus.A !== e[10:8] || bus.grant !== onehot(e[10:8]) ||
                bus.grant_valid !== (e[10:8] != 3'd0) || bus.switch_count !== e[7:0]) begin
                miscompares++;
                $display("FAIL temperature cyc%0d: got A=%0d grant=%b gv=%b cnt=%0d, want A=%0d grant=%b gv=%b cnt=%0d",
                         j, bus.A, bus.grant, bus.grant_valid, bus.switch_count,
                         e[10:8], onehot(e[10:8]), e[10:8] != 3'd0, e[7:0]);
            end
        end
    endtask

    task automatic test_alarm();
        logic [10:0] e;
        apply_reset();
        for (int j = 0; j < 20; j++) begin
            if (j == 0)      exp_q.push_back(ew(3'd0, 8'd0));
            else if (j <= 2) exp_q.push_back(ew(3'd4, 8'd1));
`ifdef ALARM_PREEMPT_EN
            else if (j == 3) exp_q.push_back(ew(3'd0, 8'd1));
            else             exp_q.push_back(ew(3'd3, 8'd2));
`else
            else if (j <= 16) exp_q.push_back(ew(3'd4, 8'd1));
            else if (j == 17) exp_q.push_back(ew(3'd0, 8'd1));
            else              exp_q.push_back(ew(3'd3, 8'd2));
`endif
        end
        for (int j = 0; j < 20; j++) begin
            drive(1'b0, 1'b0, j >= 2, 1'b1, 1'b0, 6'd20);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (bus.A !== e[10:8] || bus.grant !== onehot(e[10:8]) ||
                bus.grant_valid !== (e[10:8] != 3'd0) || bus.switch_count !== e[7:0]) begin
                miscompares++;
                $display("FAIL alarm cyc%0d: got A=%0d grant=%b gv=%b cnt=%0d, want A=%0d grant=%b gv=%b cnt=%0d",
                         j, bus.A, bus.grant, bus.grant_valid, bus.switch_count,
                         e[10:8], onehot(e[10:8]), e[10:8] != 3'd0, e[7:0]);
            end
        end
    endtask

    // SFD+SRD alternate every 17 cycles: reset mid-HOLD at count 255, then wrap 255 -> 0.
    task automatic test_wrap_reset();
        logic [10:0] e;
        int j;
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd20);
        for (int phase = 0; phase < 2; phase++) begin
            exp_q.push_back(ew(3'd0, 8'd0));
            for (int g = 1; g <= 256; g++) begin
                if (phase == 0 && g == 255) begin
                    for (int k = 0; k < 5; k++) exp_q.push_back(ew(3'd1, 8'd255));
                    break;
                end
                if (phase == 1 && g == 256) begin
                    for (int k = 0; k < 3; k++) exp_q.push_back(ew(3'd2, 8'd0));
                    break;
                end
                for (int k = 0; k < 16; k++) exp_q.push_back(ew((g % 2 == 1) ? 3'd1 : 3'd2, 8'(g)));
                exp_q.push_back(ew(3'd0, 8'(g)));
            end
            if (phase == 0) exp_q.push_back(ew(3'd0, 8'd0));
            j = 0;
            while (exp_q.size() > 0) begin
                if (phase == 0 && exp_q.size() == 1) reset = 1'b1;
                tick();
                e = exp_q.pop_front();
                vectors++;
                if (bus.A !== e[10:8] || bus.grant !== onehot(e[10:8]) ||
                    bus.grant_valid !== (e[10:8] != 3'd0) || bus.switch_count !== e[7:0]) begin
                    miscompares++;
                    $display("FAIL wrap_reset p%0d cyc%0d: got A=%0d grant=%b gv=%b cnt=%0d, want A=%0d grant=%b gv=%b cnt=%0d",
                             phase, j, bus.A, bus.grant, bus.grant_valid, bus.switch_count,
                             e[10:8], onehot(e[10:8]), e[10:8] != 3'd0, e[7:0]);
                end
                j++;
            end
            reset = 1'b0;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd20);
        test_reset();
        test_first_grant();
        test_round_robin();
        test_min_hold();
        test_temperature();
        test_alarm();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
